// File: rtl/apb_slave_regbank_pkg.sv
// Shared types and helpers for the APB3 register bank.
// State encoding, address-LSB derivation and byte-strobe merge.
package apb_regbank_pkg;

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    localparam int MAX_DW = 64;
    localparam int MAX_SB = MAX_DW / 8;
    localparam int WCNT_W = 4;

    function automatic int addr_lsb(input int dw);
        return $clog2(dw / 8);
    endfunction

    function automatic logic [MAX_DW-1:0] merge_strb(
        input logic [MAX_DW-1:0] old_v,
        input logic [MAX_DW-1:0] new_v,
        input logic [MAX_SB-1:0] strb
    );
        logic [MAX_DW-1:0] res;
        res = old_v;
        for (int k = 0; k < MAX_SB; k++) begin
            if (strb[k]) begin
                res[k*8 +: 8] = new_v[k*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB3 bus bundle for the register bank.
// Master drives request fields; slave returns data/ready/error.
interface apb_slave_regbank_if
    import apb_regbank_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 8
);
    logic                   APB_SEL;
    logic                   APB_ENABLE;
    logic                   APB_WRITE;
    logic [ADDRWIDTH-1:0]   APB_ADDR;
    logic [DATAWIDTH-1:0]   APB_WDATA;
    logic [DATAWIDTH/8-1:0] APB_STRB;
    logic [DATAWIDTH-1:0]   APB_RDATA;
    logic                   APB_READY;
    logic                   APB_SLVERR;

    modport master (
        output APB_SEL, APB_ENABLE, APB_WRITE,
        output APB_ADDR, APB_WDATA, APB_STRB,
        input  APB_RDATA, APB_READY, APB_SLVERR
    );

    modport slave (
        input  APB_SEL, APB_ENABLE, APB_WRITE,
        input  APB_ADDR, APB_WDATA, APB_STRB,
        output APB_RDATA, APB_READY, APB_SLVERR
    );

endinterface

// File: rtl/apb_wait_ctr.sv
// Wait-state counter: loads at setup, counts down during access.
// Zero flag marks the cycle the transfer may complete.
module apb_wait_ctr
    import apb_regbank_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [WCNT_W-1:0] i_load_val,
    input  logic              i_dec,
    output logic              o_zero
);

    logic [WCNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/apb_slave_regbank.sv
// Parametrised APB3 register bank with byte strobes, wait states,
// read-only status registers, PSLVERR and per-register write pulses.
module apb_slave_regbank
    import apb_regbank_pkg::*;
#(
    parameter int                  DATAWIDTH   = 32,
    parameter int                  ADDRWIDTH   = 8,
    parameter int                  NUM_REGS    = 16,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                          APB_CLK,
    input  logic                          APB_RESETn,
    apb_slave_regbank_if.slave            bus,
    output logic [NUM_REGS*DATAWIDTH-1:0] REG_OUT,
    input  logic [NUM_REGS*DATAWIDTH-1:0] REG_IN,
    output logic [NUM_REGS-1:0]           REG_WR_STB
);

    localparam int ADDR_LSB = addr_lsb(DATAWIDTH);
    localparam int IDXW     = ADDRWIDTH - ADDR_LSB;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDXW-1:0]       w_idx;
    logic [NUM_REGS-1:0]   w_hit;
    logic [NUM_REGS-1:0]   r_hit;
    logic [DATAWIDTH-1:0]  w_rd;
    logic [DATAWIDTH-1:0]  r_rdata;
    logic [DATAWIDTH-1:0]  r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_wr_stb;
    logic                  r_slverr;
    logic                  r_write;
    logic                  w_setup;
    logic                  w_access;
    logic                  w_err;
    logic                  w_zero;
    logic                  w_ready;
    logic                  w_commit;
    logic                  w_wr_en;
    logic                  w_unused;

    assign w_idx    = bus.APB_ADDR[ADDRWIDTH-1:ADDR_LSB];
    assign w_unused = ^bus.APB_ADDR[ADDR_LSB-1:0];

    assign w_setup  = (r_state == S_IDLE) && bus.APB_SEL
                      && !bus.APB_ENABLE;
    assign w_access = (r_state == S_ACCESS) && bus.APB_SEL
                      && bus.APB_ENABLE;
    assign w_ready  = (r_state == S_ACCESS) && w_zero;
    assign w_commit = w_access && w_zero;
    assign w_wr_en  = w_commit && r_write && !r_slverr;

    apb_wait_ctr u_wait_ctr (
        .i_clk      (APB_CLK),
        .i_rst_n    (APB_RESETn),
        .i_load     (w_setup),
        .i_load_val (WCNT_W'(WAIT_STATES)),
        .i_dec      (w_access),
        .o_zero     (w_zero)
    );

    // One-hot decode and read mux; RO slots return live status input.
    always_comb begin
        w_hit = '0;
        w_rd  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_hit[i] = (w_idx == IDXW'(i));
            if (w_hit[i]) begin
                w_rd = RO_MASK[i] ? REG_IN[i*DATAWIDTH +: DATAWIDTH]
                                  : r_regs[i];
            end
        end
    end

    assign w_err = ~|w_hit | (bus.APB_WRITE & |(w_hit & RO_MASK));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_setup) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!bus.APB_SEL || w_commit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge APB_CLK or negedge APB_RESETn) begin
        if (!APB_RESETn) begin
            r_state  <= S_IDLE;
            r_rdata  <= '0;
            r_slverr <= 1'b0;
            r_write  <= 1'b0;
            r_hit    <= '0;
            r_wr_stb <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_stb <= '0;
            if (w_setup) begin
                r_slverr <= w_err;
                r_write  <= bus.APB_WRITE;
                r_hit    <= w_hit;
                r_rdata  <= (!bus.APB_WRITE && !w_err) ? w_rd : '0;
            end else if (r_state == S_ACCESS
                         && w_state_nxt == S_IDLE) begin
                r_slverr <= 1'b0;
            end
            if (w_wr_en) begin
                r_wr_stb <= r_hit;
            end
        end
    end

    // RO slots are never written so they stay at zero on REG_OUT.
    always_ff @(posedge APB_CLK or negedge APB_RESETn) begin
        if (!APB_RESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (!RO_MASK[i] && w_wr_en && r_hit[i]) begin
                    r_regs[i] <= DATAWIDTH'(merge_strb(
                        MAX_DW'(r_regs[i]),
                        MAX_DW'(bus.APB_WDATA),
                        MAX_SB'(bus.APB_STRB)));
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign REG_OUT[g*DATAWIDTH +: DATAWIDTH] = r_regs[g];
    end

    assign REG_WR_STB     = r_wr_stb;
    assign bus.APB_RDATA  = r_rdata;
    assign bus.APB_READY  = w_ready;
    assign bus.APB_SLVERR = r_slverr;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: one zero-wait and one
// three-wait instance share the bus fields, selected by PSEL.
module tb_apb_slave_regbank;

    logic         clk;
    logic         rst_n;
    logic         sel0;
    logic         sel1;
    logic         enable;
    logic         write;
    logic [7:0]   addr;
    logic [31:0]  wdata;
    logic [3:0]   strb;
    logic [511:0] reg_in;
    logic [511:0] reg_out0;
    logic [511:0] reg_out1;
    logic [15:0]  stb0;
    logic [15:0]  stb1;
    logic         dsel;
    logic [31:0]  m_rdata;
    logic         m_ready;
    logic         m_slverr;
    logic [15:0]  m_stb;
    int           n_cmp;
    int           n_bad;

    logic [31:0]  rd;
    logic         err;
    int           wt;
    logic [15:0]  st;
    logic [511:0] exp_out;

    apb_slave_regbank_if #(.DATAWIDTH(32), .ADDRWIDTH(8)) bus0 ();
    apb_slave_regbank_if #(.DATAWIDTH(32), .ADDRWIDTH(8)) bus1 ();

    assign bus0.APB_SEL    = sel0;
    assign bus0.APB_ENABLE = enable;
    assign bus0.APB_WRITE  = write;
    assign bus0.APB_ADDR   = addr;
    assign bus0.APB_WDATA  = wdata;
    assign bus0.APB_STRB   = strb;
    assign bus1.APB_SEL    = sel1;
    assign bus1.APB_ENABLE = enable;
    assign bus1.APB_WRITE  = write;
    assign bus1.APB_ADDR   = addr;
    assign bus1.APB_WDATA  = wdata;
    assign bus1.APB_STRB   = strb;

    assign m_rdata  = dsel ? bus1.APB_RDATA  : bus0.APB_RDATA;
    assign m_ready  = dsel ? bus1.APB_READY  : bus0.APB_READY;
    assign m_slverr = dsel ? bus1.APB_SLVERR : bus0.APB_SLVERR;
    assign m_stb    = dsel ? stb1 : stb0;

    apb_slave_regbank #(
        .DATAWIDTH(32), .ADDRWIDTH(8), .NUM_REGS(16),
        .WAIT_STATES(0), .RO_MASK(16'h8000)
    ) u_dut0 (
        .APB_CLK    (clk),
        .APB_RESETn (rst_n),
        .bus        (bus0),
        .REG_OUT    (reg_out0),
        .REG_IN     (reg_in),
        .REG_WR_STB (stb0)
    );

    apb_slave_regbank #(
        .DATAWIDTH(32), .ADDRWIDTH(8), .NUM_REGS(16),
        .WAIT_STATES(3), .RO_MASK(16'h8000)
    ) u_dut1 (
        .APB_CLK    (clk),
        .APB_RESETn (rst_n),
        .bus        (bus1),
        .REG_OUT    (reg_out1),
        .REG_IN     (reg_in),
        .REG_WR_STB (stb1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [511:0] obs,
                        input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered #1 after a rising edge; setup starts at once so that
    // consecutive calls are back-to-back with no idle cycle.
    task automatic xfer(input logic d, input logic wr,
                        input logic [7:0] a, input logic [31:0] wd,
                        input logic [3:0] sb, output logic [31:0] o_rd,
                        output logic o_err, output int o_wt,
                        output logic [15:0] o_stb);
        dsel   = d;
        sel0   = !d;
        sel1   = d;
        enable = 1'b0;
        write  = wr;
        addr   = a;
        wdata  = wd;
        strb   = sb;
        @(posedge clk); #1;
        enable = 1'b1;
        o_wt   = 0;
        while (!m_ready && o_wt < 20) begin
            @(posedge clk); #1;
            o_wt++;
        end
        chk("ready_seen", 32'(m_ready), 1);
        o_rd  = m_rdata;
        o_err = m_slverr;
        @(posedge clk); #1;
        o_stb  = m_stb;
        sel0   = 1'b0;
        sel1   = 1'b0;
        enable = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        sel0   = 1'b0;
        sel1   = 1'b0;
        enable = 1'b0;
        write  = 1'b0;
        addr   = '0;
        wdata  = '0;
        strb   = '0;
        reg_in = '0;
        dsel   = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", bus0.APB_RDATA, 0);
        chk("rst_ready", 32'(bus0.APB_READY), 0);
        chk("rst_slverr", 32'(bus0.APB_SLVERR), 0);
        chkw("rst_regout", reg_out0, '0);
        chk("rst_stb", 32'(stb0), 0);
        chk("rst_ready1", 32'(bus1.APB_READY), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // full write then read back
        xfer(0, 1, 8'h04, 32'h1234_5678, 4'hF, rd, err, wt, st);
        chk("w1_err", 32'(err), 0);
        chk("w1_wait", 32'(wt), 0);
        chk("w1_stb", 32'(st), 32'h0002);
        chk("w1_ready_drop", 32'(m_ready), 0);
        @(posedge clk); #1;
        chk("w1_stb_once", 32'(stb0), 0);
        xfer(0, 0, 8'h04, 32'h0, 4'h0, rd, err, wt, st);
        chk("r1_data", rd, 32'h1234_5678);
        chk("r1_err", 32'(err), 0);
        chk("r1_stb", 32'(st), 0);
        chk("r1_regout", reg_out0[32 +: 32], 32'h1234_5678);

        // byte strobes 0101
        xfer(0, 1, 8'h04, 32'hAABB_CCDD, 4'b0101, rd, err, wt, st);
        xfer(0, 0, 8'h04, 32'h0, 4'h0, rd, err, wt, st);
        chk("r2_merge", rd, 32'h12BB_56DD);
        xfer(0, 0, 8'h06, 32'h0, 4'h0, rd, err, wt, st);
        chk("r2_lowbits", rd, 32'h12BB_56DD);

        // zero strobe: no data change, pulse still fires
        xfer(0, 1, 8'h04, 32'hFFFF_FFFF, 4'h0, rd, err, wt, st);
        chk("s0_stb", 32'(st), 32'h0002);
        xfer(0, 0, 8'h04, 32'h0, 4'h0, rd, err, wt, st);
        chk("s0_data", rd, 32'h12BB_56DD);

        // read-only status register
        reg_in[480 +: 32] = 32'hCAFE_0001;
        xfer(0, 0, 8'h3C, 32'h0, 4'h0, rd, err, wt, st);
        chk("ro_read", rd, 32'hCAFE_0001);
        chk("ro_read_err", 32'(err), 0);
        xfer(0, 1, 8'h3C, 32'hFFFF_FFFF, 4'hF, rd, err, wt, st);
        chk("ro_wr_err", 32'(err), 1);
        chk("ro_wr_stb", 32'(st), 0);
        xfer(0, 0, 8'h3C, 32'h0, 4'h0, rd, err, wt, st);
        chk("ro_after_wr", rd, 32'hCAFE_0001);
        chk("ro_regout", reg_out0[480 +: 32], 0);

        // status sampled at setup only
        dsel   = 1'b0;
        sel0   = 1'b1;
        enable = 1'b0;
        write  = 1'b0;
        addr   = 8'h3C;
        @(posedge clk); #1;
        reg_in[480 +: 32] = 32'h1111_1111;
        enable = 1'b1;
        #1;
        chk("ro_sample_rdy", 32'(bus0.APB_READY), 1);
        chk("ro_sample", bus0.APB_RDATA, 32'hCAFE_0001);
        @(posedge clk); #1;
        sel0   = 1'b0;
        enable = 1'b0;

        // out-of-range index 16
        xfer(0, 0, 8'h40, 32'h0, 4'h0, rd, err, wt, st);
        chk("oor_rd_data", rd, 0);
        chk("oor_rd_err", 32'(err), 1);
        xfer(0, 1, 8'h40, 32'hDEAD_BEEF, 4'hF, rd, err, wt, st);
        chk("oor_wr_err", 32'(err), 1);
        chk("oor_wr_stb", 32'(st), 0);
        exp_out = '0;
        exp_out[32 +: 32] = 32'h12BB_56DD;
        chkw("oor_regout", reg_out0, exp_out);

        // three wait states, back-to-back write then read
        xfer(1, 1, 8'h08, 32'h0BAD_F00D, 4'hF, rd, err, wt, st);
        chk("ws_wr_wait", 32'(wt), 3);
        chk("ws_wr_err", 32'(err), 0);
        chk("ws_wr_stb", 32'(st), 32'h0004);
        xfer(1, 0, 8'h08, 32'h0, 4'h0, rd, err, wt, st);
        chk("ws_rd_wait", 32'(wt), 3);
        chk("ws_b2b_data", rd, 32'h0BAD_F00D);

        // PSEL dropped mid-access
        dsel   = 1'b1;
        sel1   = 1'b1;
        enable = 1'b0;
        write  = 1'b1;
        addr   = 8'h10;
        wdata  = 32'h5555_5555;
        strb   = 4'hF;
        @(posedge clk); #1;
        enable = 1'b1;
        @(posedge clk); #1;
        sel1   = 1'b0;
        enable = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready", 32'(bus1.APB_READY), 0);
        chk("abort_slverr", 32'(bus1.APB_SLVERR), 0);
        chk("abort_stb", 32'(stb1), 0);
        chk("abort_regout", reg_out1[128 +: 32], 0);
        xfer(1, 0, 8'h10, 32'h0, 4'h0, rd, err, wt, st);
        chk("abort_rd", rd, 0);

        // reset in the middle of a waited write
        dsel   = 1'b1;
        sel1   = 1'b1;
        enable = 1'b0;
        write  = 1'b1;
        addr   = 8'h0C;
        wdata  = 32'hDEAD_BEEF;
        strb   = 4'hF;
        @(posedge clk); #1;
        enable = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus1.APB_READY), 0);
        chk("mid_rst_reg3", reg_out1[96 +: 32], 0);
        @(posedge clk); #1;
        sel1   = 1'b0;
        enable = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk); #1;
        chkw("mid_rst_regout", reg_out1, '0);
        xfer(1, 0, 8'h0C, 32'h0, 4'h0, rd, err, wt, st);
        chk("mid_rst_rd", rd, 0);
        chk("mid_rst_wait", 32'(wt), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
